// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian WALK/DON'T-WALK heads driven from the traffic light lamp codes
module ped_crossing_ctrl #(
  parameter int WALK_TIME  = 2,
  parameter int CLEAR_TIME = 3,
  parameter int TW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [1:0]    EW_lights,
  input  logic [1:0]    NS_lights,
  input  logic          ped_req_ns,
  input  logic          ped_req_ew,
  output logic          ns_walk,
  output logic          ns_dontwalk,
  output logic          ew_walk,
  output logic          ew_dontwalk,
  output logic [TW-1:0] ns_count,
  output logic [TW-1:0] ew_count,
  output logic          fault
);
  typedef enum logic [1:0] {IDLE, WALK, CLEAR} state_t;
  logic                 r_fault;
  logic                 w_fault_set;
  logic                 w_kill;
  logic [1:0]           w_walk;
  logic [1:0]           w_dontwalk;
  logic [1:0][TW-1:0]   w_count;
  logic [1:0][1:0]      w_lights;
  logic [1:0]           w_btn;
  assign w_lights    = {EW_lights, NS_lights};
  assign w_btn       = {ped_req_ew, ped_req_ns};
  assign w_fault_set = (EW_lights == 2'b10 && NS_lights == 2'b10) || EW_lights == 2'b11 || NS_lights == 2'b11;
  assign w_kill      = r_fault || w_fault_set;
  // Conflict flag latches on any green/green or invalid code and holds until reset
  always_ff @(posedge clk)
    if (rst) r_fault <= 1'b0;
    else     r_fault <= r_fault | w_fault_set;
  for (genvar g = 0; g < 2; g++) begin : g_dir
    state_t        r_state;
    logic          r_req;
    logic          r_prev;
    logic          r_flash;
    logic [TW-1:0] r_timer;
    logic          w_green;
    logic          w_rise;
    assign w_green = w_lights[g] == 2'b10;
    assign w_rise  = w_green && !r_prev;
    // Per-direction walk/clear sequencer, served on the rising edge of the parallel green
    always_ff @(posedge clk)
      if (rst) begin
        r_state <= IDLE;
        r_req   <= 1'b0;
        r_prev  <= 1'b0;
        r_flash <= 1'b0;
        r_timer <= '0;
      end else begin
        r_prev <= w_green;
        r_req  <= r_req | w_btn[g];
        if (w_kill) begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_flash <= 1'b0;
          r_timer <= '0;
        end else begin
          case (r_state)
            IDLE:
              if (w_rise && (r_req || w_btn[g])) begin
                r_state <= WALK;
                r_timer <= TW'(WALK_TIME);
                r_req   <= 1'b0;
              end
            WALK:
              if (!w_green) begin
                r_state <= IDLE;
                r_timer <= '0;
              end else if (tick) begin
                if (r_timer == TW'(1)) begin
                  r_state <= CLEAR;
                  r_timer <= TW'(CLEAR_TIME);
                  r_flash <= 1'b1;
                end else r_timer <= r_timer - TW'(1);
              end
            CLEAR:
              if (w_lights[g] == 2'b00 || w_lights[g] == 2'b11) begin
                r_state <= IDLE;
                r_timer <= '0;
              end else if (tick) begin
                r_flash <= ~r_flash;
                if (r_timer == TW'(1)) begin
                  r_state <= IDLE;
                  r_timer <= '0;
                end else r_timer <= r_timer - TW'(1);
              end
            default: r_state <= IDLE;
          endcase
        end
      end
    assign w_walk[g]     = r_state == WALK;
    assign w_dontwalk[g] = r_state == WALK ? 1'b0 : r_state == CLEAR ? r_flash : 1'b1;
    assign w_count[g]    = r_state == CLEAR ? r_timer : '0;
  end
  assign ns_walk     = w_walk[0];
  assign ew_walk     = w_walk[1];
  assign ns_dontwalk = w_dontwalk[0];
  assign ew_dontwalk = w_dontwalk[1];
  assign ns_count    = w_count[0];
  assign ew_count    = w_count[1];
  assign fault       = r_fault;
endmodule

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
- Downstream consumer of the 4-way traffic light FSM.
- Watches the registered EW/NS lamp codes and drives the pedestrian WALK / DON'T-WALK heads for the NS and EW crosswalks.
- Pedestrian pushbutton requests are latched and served on the next green of the parallel traffic direction, with a timed walk phase, a flashing clearance countdown, and a sticky conflict fault that forces every head to solid DON'T-WALK.

Parameters:
- WALK_TIME, 2, walk phase length in ticks; must be >= 1.
- CLEAR_TIME, 3, flashing clearance length in ticks; must be >= 1.
- TW, 4, timer and countdown width; WALK_TIME and CLEAR_TIME must each be < 2^TW.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- tick  input  1  one-cycle time-base strobe (1 s). Tie high when one clock equals one second, as in the light FSM.
- EW_lights  input  2  EW lamp code: 00 RED, 01 YELLOW, 10 GREEN, 11 invalid.
- NS_lights  input  2  NS lamp code, same encoding as EW_lights.
- ped_req_ns  input  1  NS crosswalk button, level, sampled every cycle.
- ped_req_ew  input  1  EW crosswalk button, level, sampled every cycle.
- ns_walk  output  1  NS WALK lamp.
- ns_dontwalk  output  1  NS DON'T-WALK lamp.
- ew_walk  output  1  EW WALK lamp.
- ew_dontwalk  output  1  EW DON'T-WALK lamp.
- ns_count  output  TW  NS clearance ticks remaining; 0 outside CLEAR.
- ew_count  output  TW  EW clearance ticks remaining; 0 outside CLEAR.
- fault  output  1  sticky conflict flag.

Behaviour:
- Clocking and reset:
  - Single clock, all state updates on posedge clk.
  - rst is synchronous, active-high, and has priority over everything else.
  - Reset values: both FSMs IDLE, request latches 0, prev_green 0, timers 0, fault 0.
  - Reset output values: walk 0, dontwalk 1, count 0.
- Outputs are Moore, decoded from registered state. Input seen before edge k is reflected in outputs right after edge k (1-cycle latency).
- Structure: two identical per-direction FSMs (d = NS, EW). Each keyed to its own lights input, its own button and its own prev_green register.
- green_rise_d = (d_lights == 10) && !prev_green_d. prev_green_d <= (d_lights == 10) every cycle.
- Request latch req_d:
  - Set when ped_req_d = 1.
  - Cleared on the IDLE->WALK transition. Clear wins over a press in the same cycle, because that press is served.
  - Presses during WALK or CLEAR set req_d for the next green.
- IDLE (walk 0, dontwalk 1, count 0):
  - Go to WALK, with timer <= WALK_TIME, when green_rise_d && (req_d || ped_req_d) && !fault.
  - Otherwise stay in IDLE. A request arriving after the rise waits for the next green.
- WALK (walk 1, dontwalk 0, count 0):
  - If d_lights != 10: go to IDLE immediately. This check has priority over tick.
  - Else on tick: if timer == 1, go to CLEAR with timer <= CLEAR_TIME and flash <= 1; otherwise timer - 1.
- CLEAR (walk 0, dontwalk = flash, count = timer):
  - If d_lights == 00 or 11: go to IDLE. YELLOW does not abort CLEAR.
  - Else on tick: flash toggles. If timer == 1, go to IDLE; otherwise timer - 1.
- Fault:
  - Set when EW_lights == 10 && NS_lights == 10, or when either code == 11.
  - Sticky until rst.
  - Same edge fault is set: both FSMs go to IDLE and req latches clear.
  - While fault = 1: all walk 0, dontwalk 1, counts 0, no WALK entry.
- Timers are unsigned TW-bit and never decrement below 1 inside WALK/CLEAR, so there is no wrap.
- tick = 0 freezes timers and flash; abort and fault checks still run every cycle.

Test Plan:
- Reset walk-through:
  - Stimulus: rst 1 for 2 cycles with NS=10, EW=00, tick=1, no buttons.
  - Required: all walk 0, dontwalk 1, counts 0, fault 0. After release, no WALK, since no request.
- NS serve with tick=1:
  - Stimulus: ped_req_ns pulse while NS=00; then NS goes 10 and holds 6 cycles, then 01.
  - Required: ns_walk=1 for exactly 2 cycles starting 1 cycle after green.
  - Then CLEAR 3 cycles: ns_count 3,2,1; ns_dontwalk 1,0,1.
  - Then IDLE: dontwalk 1, count 0, req cleared.
- Early abort:
  - Stimulus: NS green drops to 01 during WALK.
  - Required: next cycle ns_walk 0, dontwalk 1, IDLE.
  - Contrast: NS=01 during CLEAR keeps the countdown running; NS=00 during CLEAR forces IDLE.
- Late request:
  - Stimulus: ped_req_ew asserted 2 cycles after EW rise.
  - Required: no walk this green. Walk on the next EW rise, 1 cycle after it.
- Conflict fault:
  - Stimulus: NS=10 and EW=10 for 1 cycle, mid-WALK.
  - Required: fault=1 next cycle, all heads dontwalk 1, counts 0.
  - Stays set through later valid greens and pending requests until rst.
- Slow time base:
  - Stimulus: tick every 4th cycle.
  - Required: WALK lasts 8 cycles, flash toggles only on ticks, ns_count steps on ticks.
